upower_fetch_unit: RTL

Instruction fetch stage for the uPOWER core. It holds the program counter and a synchronous-read instruction memory, and produces the 32-bit `Instruction` word consumed by the decode/execute datapath through a valid/ready handshake. It accepts branch/jump redirects from downstream and supports backpressure. An optional prefetch buffer sustains one instruction per cycle.

---
 rtl/upower_fetch_pkg.sv | 21 ++
 rtl/upower_prefetch_fifo.sv | 72 +++++++
 rtl/upower_fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/upower_fetch_pkg.sv
// Shared types and constants for the uPOWER instruction fetch stage.
// Buffer entries carry the instruction word together with its byte PC.
package upower_fetch_pkg;

    localparam int                 INSTR_W    = 32;
    localparam logic [31:0]        PC_STEP    = 32'd4;
    localparam logic [INSTR_W-1:0] UPOWER_NOP = 32'h6000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

    function automatic fetch_entry_t nop_entry();
        fetch_entry_t e;
        e.instr = UPOWER_NOP;
        e.pc    = '0;
        return e;
    endfunction

endpackage

// File: rtl/upower_prefetch_fifo.sv
// Fetch-entry FIFO with flush; push lands after one edge, head is combinational.
// Caller guarantees no push when full and no pop when empty; flush overrides both.
module upower_prefetch_fifo
    import upower_fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    output logic         out_vld,
    output fetch_entry_t out_dat,
    output logic [CW-1:0] count
);

    fetch_entry_t   entries_q [2**PW];
    fetch_entry_t   entries_d [2**PW];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                entries_d[wr_ptr_q] = push_dat;
                wr_ptr_d            = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**PW; i++) begin
                entries_q[i] <= nop_entry();
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_vld = (cnt_q != '0);
    assign out_dat = entries_q[rd_ptr_q];
    assign count   = cnt_q;

endmodule

// File: rtl/upower_fetch_unit.sv
// uPOWER fetch: PC + sync-read IMEM feeding a valid/ready output; first word valid two edges after reset release.
// Stalls hold the head word; UPOWER_FETCH_PREFETCH_BUF_EN selects a 2-deep buffer for one word per cycle.
module upower_fetch_unit
    import upower_fetch_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    input  logic                          redirect,
    input  logic [31:0]                   redirect_pc,
    input  logic                          instr_ready,
    output logic                          instr_valid,
    output logic [31:0]                   instr_out,
    output logic [31:0]                   instr_pc
);

`ifdef UPOWER_FETCH_PREFETCH_BUF_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    logic [INSTR_W-1:0] rd_dat_q;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        rd_pc_q, rd_pc_d;
    logic               inflight_q, inflight_d;
    logic               issue, buf_push, buf_pop, buf_vld;
    logic [2:0]         credits;
    logic [CW-1:0]      buf_cnt;
    fetch_entry_t       push_entry, buf_head;

    assign buf_pop = buf_vld && instr_ready;

    // A word drained at this edge frees its slot in time for the new read.
    always_comb begin
        credits    = 3'(buf_cnt) + 3'(inflight_q) - 3'(buf_pop);
        issue      = !redirect && (credits < 3'(BUF_DEPTH));
        pc_d       = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (issue) begin
            pc_d = pc_q + PC_STEP;
        end
        rd_pc_d          = issue ? pc_q : rd_pc_q;
        inflight_d       = issue;
        buf_push         = inflight_q && !redirect;
        push_entry.instr = rd_dat_q;
        push_entry.pc    = rd_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= PC_RESET;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Program memory keeps its contents through reset; same-edge write returns old data.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
        if (issue) begin
            rd_dat_q <= imem[pc_q[2 +: AW]];
        end
    end

    upower_prefetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .push     (buf_push),
        .push_dat (push_entry),
        .pop      (buf_pop),
        .out_vld  (buf_vld),
        .out_dat  (buf_head),
        .count    (buf_cnt)
    );

    assign instr_valid = buf_vld;
    assign instr_out   = buf_vld ? buf_head.instr : '0;
    assign instr_pc    = buf_vld ? buf_head.pc    : '0;

endmodule
